uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
//   Byte buffer directly downstream of the UART receiver. Captures each byte on the
//   receiver's single-cycle rx_done pulse and holds it until the consumer pops it
//   through a valid/ready port. Decouples bursty serial arrival from a slow consumer.
//   Flags overrun when a byte arrives with the buffer full.
// PARAMETERS
//   DATA_W        8    width of one stored word (receiver byte)
//   DEPTH         16   number of entries; power of two, >= 2
//   AFULL_THRESH  12   almost_full asserts when occupancy >= this value; 1..DEPTH
// PORTS
//   clk          in   1               clock
//   rst          in   1               synchronous, active-high reset
//   wr_en        in   1               push strobe; wired to receiver rx_done (1-cycle pulse)
//   wr_data      in   DATA_W          push data; wired to receiver data_out
//   m_valid      out  1               head entry available
//   m_data       out  DATA_W          head entry, valid while m_valid=1
//   m_ready      in   1               consumer accepts head; pop when m_valid & m_ready
//   full         out  1               occupancy == DEPTH
//   empty        out  1               occupancy == 0
//   almost_full  out  1               occupancy >= AFULL_THRESH
//   overrun      out  1               sticky: a push was dropped
//   ovr_clr      in   1               clears overrun
// BEHAVIOUR
//   - Reset: rd/wr pointers 0, occupancy 0, overrun 0 -> m_valid 0, empty 1, full 0,
//     almost_full 0. m_data don't-care. Reset mid-stream discards all stored bytes.
//   - Storage: DEPTH x DATA_W array, write port synchronous, read port combinational
//     from rd_ptr (show-ahead). m_data = mem[rd_ptr]; m_valid = !empty.
//   - Pointers: log2(DEPTH)+1 bits each; low bits index, MSB is wrap bit.
//     empty = (wr_ptr == rd_ptr); full = index equal & wrap bits differ.
//     Occupancy = wr_ptr - rd_ptr (modulo 2^(log2(DEPTH)+1)). Wrap-around from
//     DEPTH-1 to 0 is implicit in pointer increment.
//   - Latency: byte pushed at edge N -> m_valid=1 with that byte after edge N
//     (visible in cycle N+1). Pop at edge N -> next head visible cycle N+1.
//   - Pop: occurs when m_valid & m_ready; rd_ptr++. m_ready while empty is ignored.
//   - Push accepted when !full, or when full and a pop occurs the same cycle
//     (occupancy unchanged, both pointers advance).
//   - Push when full and no pop: byte dropped, pointers unchanged, overrun <= 1.
//   - Push and pop same cycle when not full/not empty: occupancy unchanged.
//   - Push while empty: no same-cycle bypass; byte appears next cycle.
//   - overrun: set by dropped push, cleared by ovr_clr; set and clear in the same
//     cycle -> set wins (overrun=1). Stays 1 until cleared or reset.
//   - All flag outputs are combinational from registered pointers; no glitches
//     on registered state at reset release.
// CONFIGURATION
//   UART_RX_FIFO_LEVEL_EN defined: adds output port
//     level  out  $clog2(DEPTH)+1  current occupancy (0..DEPTH), same timing as flags.
//   Not defined: port absent; behaviour otherwise identical.
// STRUCTURE
//   uart_pkg: UART_DATA_W (=8) constant, shared with receiver; ptr width function.
//   Sub-module uart_fifo_mem: DEPTH x DATA_W array, sync write, async read.
//   Pointer/flag/overrun logic stays in uart_rx_fifo.
// TESTING
//   1. Reset, then push 0xA5 -> next cycle m_valid=1, m_data=0xA5, empty=0.
//   2. Push 0x00..0x0F (16) with m_ready=0 -> full=1, almost_full=1 from 12th push;
//      pop all -> data 0x00..0x0F in order, empty=1 after last pop.
//   3. Full, push 0x55 with m_ready=0 -> overrun=1, contents unchanged; ovr_clr -> 0.
//   4. Full, push 0x77 with m_ready=1 same cycle -> no overrun, 0x77 read 16th later.
//   5. Push 5 bytes, assert rst for 1 cycle -> empty=1, m_valid=0, overrun=0.
//   6. Pointer wrap: 40 interleaved push/pop cycles -> order preserved, no flag error;
//      with UART_RX_FIFO_LEVEL_EN, level matches model every cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants: receiver byte width and the FIFO pointer-width helper.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  // One extra bit above the index so full and empty can be told apart.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W storage for the UART receive FIFO: synchronous write, combinational read.
module uart_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Byte FIFO behind the UART receiver with show-ahead valid/ready output and sticky overrun.
// Define UART_RX_FIFO_LEVEL_EN to add the occupancy output 'level'.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W       = UART_DATA_W,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              overrun,
  input  logic              ovr_clr
`ifdef UART_RX_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] level
`endif
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int AW    = PTR_W - 1;
  localparam logic [PTR_W-1:0] AFULL_LVL = PTR_W'(AFULL_THRESH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  logic [PTR_W-1:0] wr_ptr, rd_ptr, occ;
  logic             pop, push, drop;

  // Handshake: a word transfers on every edge where m_valid && m_ready; m_valid never
  // depends on m_ready, and m_data is stable while m_valid is high and m_ready is low.
  assign occ         = wr_ptr - rd_ptr;
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign almost_full = (occ >= AFULL_LVL);
  assign m_valid     = !empty;

  // A pop frees a slot in the same cycle, so a push into a full buffer still lands.
  assign pop  = m_valid && m_ready;
  assign push = wr_en && (!full || pop);
  assign drop = wr_en && full && !pop;

`ifdef UART_RX_FIFO_LEVEL_EN
  assign level = occ;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      overrun <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      // Set has priority so a drop coinciding with a clear is never lost.
      if (drop)         overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end

  uart_fifo_mem #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr[AW-1:0]),
    .wdata(wr_data),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(m_data)
  );

endmodule
